// File: rtl/trap_ctrl_pkg.sv
// Shared types for the machine-mode trap controller: PC geometry, CSR field layouts,
// exception/interrupt cause codes and the trap FSM state encoding.
package trap_ctrl_pkg;

    localparam int unsigned PC_LEN   = 30;
    localparam int unsigned PC_ZEROS = 2;

    localparam logic [30:0] EXC_MISALIGNED = 31'd0;
    localparam logic [30:0] EXC_ILLEGAL    = 31'd2;
    localparam logic [30:0] EXC_EBREAK     = 31'd3;
    localparam logic [30:0] EXC_ECALL      = 31'd11;
    localparam logic [30:0] INT_MSI        = 31'd3;
    localparam logic [30:0] INT_MTI        = 31'd7;
    localparam logic [30:0] INT_MEI        = 31'd11;

    typedef struct packed {
        logic [18:0] rsvd_hi;
        logic [1:0]  mpp;
        logic [2:0]  rsvd_mid;
        logic        mpie;
        logic [2:0]  rsvd_lo;
        logic        mie;
        logic [2:0]  rsvd_low;
    } mstatus_t;

    typedef struct packed {
        logic meie;
        logic mtie;
        logic msie;
    } mie_m_only_t;

    typedef struct packed {
        logic meip;
        logic mtip;
        logic msip;
    } mip_m_only_t;

    typedef struct packed {
        logic [29:0] base;
        logic [1:0]  mode;
    } mtvec_t;

    typedef struct packed {
        logic        irq;
        logic [30:0] code;
    } mcause_t;

    typedef enum logic [1:0] {IDLE, ENTER, RETURN} trap_state_e;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational cause selection: any exception beats any interrupt, each class in its
// own fixed priority order.
module trap_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic       exc_misaligned,
    input  logic       exc_illegal,
    input  logic       exc_ebreak,
    input  logic       exc_ecall,
    input  logic [2:0] irq_pending,  // {mei, mti, msi}, already globally enabled
    output logic       exc_valid,
    output logic       irq_valid,
    output mcause_t    cause
);

    always_comb begin
        exc_valid = exc_misaligned | exc_illegal | exc_ebreak | exc_ecall;
        irq_valid = |irq_pending;
        cause     = '0;
        if (exc_misaligned) begin
            cause = '{irq: 1'b0, code: EXC_MISALIGNED};
        end else if (exc_illegal) begin
            cause = '{irq: 1'b0, code: EXC_ILLEGAL};
        end else if (exc_ebreak) begin
            cause = '{irq: 1'b0, code: EXC_EBREAK};
        end else if (exc_ecall) begin
            cause = '{irq: 1'b0, code: EXC_ECALL};
        end else if (irq_pending[2]) begin
            cause = '{irq: 1'b1, code: INT_MEI};
        end else if (irq_pending[0]) begin
            cause = '{irq: 1'b1, code: INT_MSI};
        end else if (irq_pending[1]) begin
            cause = '{irq: 1'b1, code: INT_MTI};
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: takes exceptions/interrupts/mret, drives the CSR trap update
// and the pipeline redirect. Define TRAP_VECTORED_EN for vectored interrupt targets.
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_async,
    input  logic              stall_n,
    input  logic              instr_valid,
    input  logic [PC_LEN-1:0] instr_pc,
    input  logic              exc_misaligned,
    input  logic              exc_illegal,
    input  logic              exc_ebreak,
    input  logic              exc_ecall,
    input  logic              mret,
    input  mstatus_t          csr_mstatus,
    input  mie_m_only_t       csr_mie,
    input  mip_m_only_t       csr_mip,
    input  mtvec_t            csr_mtvec,
    input  logic [PC_LEN-1:0] csr_mepc,
    output logic              trap_occurred,
    output logic              trap_returned,
    output logic [PC_LEN-1:0] new_mepc,
    output mcause_t           new_mcause,
    output logic              flush,
    output logic              hold,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc
);

    trap_state_e       state_q, state_d;
    logic [PC_LEN-1:0] mepc_q, mepc_d;
    mcause_t           mcause_q, mcause_d;

    logic [2:0] ie, ip, irq_pending;
    logic       exc_valid, irq_valid, take;
    mcause_t    cause;
    logic [31:0] base_addr, trap_target;
    logic        unused_bits;

    assign ie          = csr_mie;
    assign ip          = csr_mip;
    assign irq_pending = {3{csr_mstatus.mie}} & ie & ip;
    assign take        = stall_n & instr_valid & (state_q == IDLE);

    trap_prio_enc u_prio (
        .exc_misaligned (exc_misaligned),
        .exc_illegal    (exc_illegal),
        .exc_ebreak     (exc_ebreak),
        .exc_ecall      (exc_ecall),
        .irq_pending    (irq_pending),
        .exc_valid      (exc_valid),
        .irq_valid      (irq_valid),
        .cause          (cause)
    );

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q  <= IDLE;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            state_q  <= state_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    // Exception > mret > interrupt; the ENTER/RETURN states mask everything.
    always_comb begin
        state_d  = state_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        flush    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (take && (exc_valid || (!mret && irq_valid))) begin
                    mepc_d   = instr_pc;
                    mcause_d = cause;
                    flush    = 1'b1;
                    state_d  = ENTER;
                end else if (take && mret) begin
                    flush   = 1'b1;
                    state_d = RETURN;
                end
            end
            ENTER:   state_d = IDLE;
            RETURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign base_addr = {csr_mtvec.base, 2'b00};

`ifdef TRAP_VECTORED_EN
    assign trap_target = (csr_mtvec.mode == 2'd1 && mcause_q.irq)
                       ? base_addr + {mcause_q.code[29:0], 2'b00}
                       : base_addr;
`else
    assign trap_target = base_addr;
`endif

    assign unused_bits = ^{csr_mstatus, csr_mtvec.mode, mcause_q};

    always_comb begin
        trap_occurred  = (state_q == ENTER);
        trap_returned  = (state_q == RETURN);
        hold           = trap_occurred | trap_returned;
        redirect_valid = hold;
        redirect_pc    = '0;
        if (trap_occurred) begin
            redirect_pc = trap_target;
        end else if (trap_returned) begin
            redirect_pc = {csr_mepc, {PC_ZEROS{1'b0}}};
        end
    end

    assign new_mepc   = mepc_q;
    assign new_mcause = mcause_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: entry, vectoring, priorities, mret, stalls and mid-trap reset.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    logic              clk;
    logic              rst_async;
    logic              stall_n;
    logic              instr_valid;
    logic [PC_LEN-1:0] instr_pc;
    logic              exc_misaligned, exc_illegal, exc_ebreak, exc_ecall;
    logic              mret;
    mstatus_t          csr_mstatus;
    mie_m_only_t       csr_mie;
    mip_m_only_t       csr_mip;
    mtvec_t            csr_mtvec;
    logic [PC_LEN-1:0] csr_mepc;
    logic              trap_occurred, trap_returned, flush, hold, redirect_valid;
    logic [PC_LEN-1:0] new_mepc;
    mcause_t           new_mcause;
    logic [31:0]       redirect_pc;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_vec;

    trap_ctrl dut (
        .clk            (clk),
        .rst_async      (rst_async),
        .stall_n        (stall_n),
        .instr_valid    (instr_valid),
        .instr_pc       (instr_pc),
        .exc_misaligned (exc_misaligned),
        .exc_illegal    (exc_illegal),
        .exc_ebreak     (exc_ebreak),
        .exc_ecall      (exc_ecall),
        .mret           (mret),
        .csr_mstatus    (csr_mstatus),
        .csr_mie        (csr_mie),
        .csr_mip        (csr_mip),
        .csr_mtvec      (csr_mtvec),
        .csr_mepc       (csr_mepc),
        .trap_occurred  (trap_occurred),
        .trap_returned  (trap_returned),
        .new_mepc       (new_mepc),
        .new_mcause     (new_mcause),
        .flush          (flush),
        .hold           (hold),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, "_trap_occurred"}, trap_occurred, 1'b0);
        chk1({tag, "_trap_returned"}, trap_returned, 1'b0);
        chk1({tag, "_flush"}, flush, 1'b0);
        chk1({tag, "_hold"}, hold, 1'b0);
        chk1({tag, "_redirect_valid"}, redirect_valid, 1'b0);
        chk32({tag, "_new_mepc"}, 32'(new_mepc), 32'h0);
        chk32({tag, "_new_mcause"}, new_mcause, 32'h0);
        chk32({tag, "_redirect_pc"}, redirect_pc, 32'h0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef TRAP_VECTORED_EN
        exp_vec = 32'h0000_021C;
`else
        exp_vec = 32'h0000_0200;
`endif
        rst_async = 1'b1;
        stall_n = 1'b1; instr_valid = 1'b0; instr_pc = '0;
        exc_misaligned = 1'b0; exc_illegal = 1'b0; exc_ebreak = 1'b0; exc_ecall = 1'b0;
        mret = 1'b0; csr_mstatus = '0; csr_mie = '0; csr_mip = '0;
        csr_mtvec = mtvec_t'(32'h200); csr_mepc = '0;
        #12;
        chk_zero("reset");
        next(); rst_async = 1'b0;

        // ecall at pc 0x40, direct target
        next(); instr_valid = 1'b1; exc_ecall = 1'b1; instr_pc = 30'h40;
        @(negedge clk);
        chk1("ecall_flush", flush, 1'b1);
        chk1("ecall_no_early_pulse", trap_occurred, 1'b0);
        next(); instr_valid = 1'b0; exc_ecall = 1'b0;
        @(negedge clk);
        chk1("ecall_trap_occurred", trap_occurred, 1'b1);
        chk1("ecall_redirect_valid", redirect_valid, 1'b1);
        chk1("ecall_hold", hold, 1'b1);
        chk1("ecall_flush_off", flush, 1'b0);
        chk32("ecall_mepc", 32'(new_mepc), 32'h40);
        chk32("ecall_mcause", new_mcause, 32'h0000_000B);
        chk32("ecall_redirect_pc", redirect_pc, 32'h200);
        next();
        @(negedge clk);
        chk1("ecall_pulse_one_cycle", trap_occurred, 1'b0);
        chk32("ecall_redirect_pc_idle", redirect_pc, 32'h0);

        // timer interrupt with mtvec mode 1
        next();
        csr_mstatus.mie = 1'b1; csr_mie = 3'b010; csr_mip = 3'b010;
        csr_mtvec = mtvec_t'(32'h201); instr_valid = 1'b1; instr_pc = 30'h50;
        @(negedge clk);
        chk1("mti_flush", flush, 1'b1);
        next(); instr_valid = 1'b0; csr_mstatus = '0;
        @(negedge clk);
        chk1("mti_trap_occurred", trap_occurred, 1'b1);
        chk32("mti_mcause", new_mcause, 32'h8000_0007);
        chk32("mti_redirect_pc", redirect_pc, exp_vec);
        chk32("mti_mepc", 32'(new_mepc), 32'h50);

        // illegal beats all three pending interrupts
        next();
        csr_mstatus.mie = 1'b1; csr_mie = 3'b111; csr_mip = 3'b111;
        csr_mtvec = mtvec_t'(32'h200); instr_valid = 1'b1; exc_illegal = 1'b1; instr_pc = 30'h60;
        @(negedge clk);
        chk1("illegal_flush", flush, 1'b1);
        next(); exc_illegal = 1'b0; csr_mstatus.mie = 1'b0;
        @(negedge clk);
        chk32("illegal_mcause", new_mcause, 32'h0000_0002);
        chk1("irq_masked_in_enter", flush, 1'b0);
        next();
        @(negedge clk);
        chk1("irq_blocked_after_mie_clear", flush, 1'b0);
        chk1("irq_blocked_no_pulse", trap_occurred, 1'b0);

        // mret with MSI pending: return first, then MSI
        next();
        csr_mstatus.mie = 1'b1; csr_mie = 3'b001; csr_mip = 3'b001;
        csr_mepc = 30'h80; mret = 1'b1; instr_valid = 1'b1;
        @(negedge clk);
        chk1("mret_flush", flush, 1'b1);
        chk1("mret_not_trap", trap_occurred, 1'b0);
        next(); mret = 1'b0;
        @(negedge clk);
        chk1("mret_trap_returned", trap_returned, 1'b1);
        chk1("mret_redirect_valid", redirect_valid, 1'b1);
        chk32("mret_redirect_pc", redirect_pc, 32'h200);
        chk1("mret_no_trap_pulse", trap_occurred, 1'b0);
        next();
        @(negedge clk);
        chk1("msi_after_mret_flush", flush, 1'b1);
        next(); instr_valid = 1'b0; csr_mstatus.mie = 1'b0;
        @(negedge clk);
        chk1("msi_trap_occurred", trap_occurred, 1'b1);
        chk32("msi_mcause", new_mcause, 32'h8000_0003);
        next(); csr_mie = '0; csr_mip = '0;

        // stall blocks taking; held ecall then traps back to back
        stall_n = 1'b0; instr_valid = 1'b1; exc_ecall = 1'b1; instr_pc = 30'h70;
        @(negedge clk);
        chk1("stall_no_flush", flush, 1'b0);
        next();
        @(negedge clk);
        chk1("stall_no_flush2", flush, 1'b0);
        chk1("stall_no_pulse", trap_occurred, 1'b0);
        next(); stall_n = 1'b1;
        @(negedge clk);
        chk1("unstall_flush", flush, 1'b1);
        next();
        @(negedge clk);
        chk1("b2b_first_pulse", trap_occurred, 1'b1);
        chk1("b2b_no_flush_in_enter", flush, 1'b0);
        next();
        @(negedge clk);
        chk1("b2b_gap", trap_occurred, 1'b0);
        chk1("b2b_second_flush", flush, 1'b1);
        next(); instr_valid = 1'b0; exc_ecall = 1'b0;
        @(negedge clk);
        chk1("b2b_second_pulse", trap_occurred, 1'b1);

        // exception priority
        next(); instr_valid = 1'b1; exc_misaligned = 1'b1; exc_ebreak = 1'b1;
        next(); instr_valid = 1'b0; exc_misaligned = 1'b0; exc_ebreak = 1'b0;
        @(negedge clk);
        chk32("misaligned_over_ebreak", new_mcause, 32'h0000_0000);
        next();
        next(); instr_valid = 1'b1; exc_ebreak = 1'b1; exc_ecall = 1'b1;
        next(); instr_valid = 1'b0; exc_ebreak = 1'b0; exc_ecall = 1'b0;
        @(negedge clk);
        chk32("ebreak_over_ecall", new_mcause, 32'h0000_0003);
        next();

        // reset asserted during ENTER
        next(); instr_valid = 1'b1; exc_ecall = 1'b1; instr_pc = 30'h90;
        next(); instr_valid = 1'b0; exc_ecall = 1'b0;
        chk1("pre_reset_in_enter", trap_occurred, 1'b1);
        rst_async = 1'b1;
        #1;
        chk_zero("reset_mid_enter");
        next(); rst_async = 1'b0;
        @(negedge clk);
        chk_zero("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
